// File: rtl/note_player.sv
// Note timing and phase generation: latches a note from the song reader, fetches its
// phase step from the frequency ROM, counts beats and advances the phase on request.
module note_player #(
   parameter int unsigned STEP_W  = 20,
   parameter int unsigned PHASE_W = 22
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               play_enable,
   input  logic [5:0]         note_to_load,
   input  logic [5:0]         duration_to_load,
   input  logic               load_new_note,
   input  logic               beat,
   input  logic               generate_next_sample,
   output logic [5:0]         freq_rom_addr,
   input  logic [STEP_W-1:0]  freq_rom_data,
   output logic [PHASE_W-1:0] phase,
   output logic               sample_valid,
   output logic               note_active,
   output logic               done_with_note
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] PLAY  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [5:0]         addr_q, addr_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [5:0]         count_q, count_d;
   logic               sample_valid_q, sample_valid_d;
   logic               done_q, done_d;

   always_comb begin
      state_d        = state_q;
      addr_d         = addr_q;
      phase_d        = phase_q;
      step_d         = step_q;
      count_d        = count_q;
      sample_valid_d = 1'b0;
      done_d         = 1'b0;

      // A load pre-empts everything, including a coincident final beat.
      if (load_new_note) begin
         addr_d  = note_to_load;
         count_d = duration_to_load;
         phase_d = '0;
         state_d = FETCH;
      end else begin
         unique case (state_q)
            IDLE: begin
            end
            FETCH: begin
               step_d  = freq_rom_data;
               state_d = PLAY;
               // Zero-length notes end as soon as the step is in hand.
               if (play_enable && (count_q == 6'd0)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            PLAY: begin
               if (play_enable) begin
                  if (generate_next_sample) begin
                     sample_valid_d = 1'b1;
                     phase_d = (addr_q != 6'd0) ? phase_q + PHASE_W'(step_q) : '0;
                  end
                  if (count_q == 6'd0) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else if (beat) begin
                     count_d = count_q - 6'd1;
                     if (count_q == 6'd1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         addr_q         <= '0;
         phase_q        <= '0;
         step_q         <= '0;
         count_q        <= '0;
         sample_valid_q <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         phase_q        <= phase_d;
         step_q         <= step_d;
         count_q        <= count_d;
         sample_valid_q <= sample_valid_d;
         done_q         <= done_d;
      end
   end

   assign freq_rom_addr  = addr_q;
   assign phase          = phase_q;
   assign sample_valid   = sample_valid_q;
   assign done_with_note = done_q;
   assign note_active    = (state_q == PLAY) && (addr_q != 6'd0);

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player: a vector table for the plain note/rest/wrap cases and
// hand-written sequences for pause, zero duration, retrigger and mid-note reset.
module tb_note_player;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        play_enable = 1'b1;
   logic [5:0]  note_to_load = '0;
   logic [5:0]  duration_to_load = '0;
   logic        load_new_note = 1'b0;
   logic        beat = 1'b0;
   logic        generate_next_sample = 1'b0;
   logic [5:0]  freq_rom_addr;
   logic [19:0] freq_rom_data;
   logic [21:0] phase;
   logic        sample_valid;
   logic        note_active;
   logic        done_with_note;

   int n_cmp = 0;
   int n_bad = 0;

   note_player #(.STEP_W(20), .PHASE_W(22)) dut (
      .clk                  (clk),
      .reset                (reset),
      .play_enable          (play_enable),
      .note_to_load         (note_to_load),
      .duration_to_load     (duration_to_load),
      .load_new_note        (load_new_note),
      .beat                 (beat),
      .generate_next_sample (generate_next_sample),
      .freq_rom_addr        (freq_rom_addr),
      .freq_rom_data        (freq_rom_data),
      .phase                (phase),
      .sample_valid         (sample_valid),
      .note_active          (note_active),
      .done_with_note       (done_with_note)
   );

   always #5 clk = ~clk;

   // Frequency ROM model: data follows the address within the same cycle.
   always_comb begin
      case (freq_rom_addr)
         6'd3:    freq_rom_data = 20'h00010;
         6'd4:    freq_rom_data = 20'h00020;
         6'd5:    freq_rom_data = 20'h00100;
         6'd7:    freq_rom_data = 20'hFFFFF;
         default: freq_rom_data = 20'h00001;
      endcase
   end

   typedef struct {
      logic        ld;
      logic [5:0]  nt;
      logic [5:0]  dr;
      logic        bt;
      logic        gn;
      logic [21:0] ph;
      logic        sv;
      logic        dn;
      logic        act;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic ld, logic [5:0] nt, logic [5:0] dr, logic bt, logic gn,
                               logic [21:0] ph, logic sv, logic dn, logic act);
      vec_t v;
      v.ld = ld; v.nt = nt; v.dr = dr; v.bt = bt; v.gn = gn;
      v.ph = ph; v.sv = sv; v.dn = dn; v.act = act;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply inputs for one cycle, then settle just after the edge.
   task automatic cyc(input logic ld, input logic [5:0] nt, input logic [5:0] dr,
                      input logic bt, input logic gn);
      load_new_note        = ld;
      note_to_load         = nt;
      duration_to_load     = dr;
      beat                 = bt;
      generate_next_sample = gn;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cyc();
      cyc(1'b0, 6'd0, 6'd0, 1'b0, 1'b0);
   endtask

   initial begin
      // Note 5 dur 3: four requests of step 0x100, done after the third beat.
      vecs.push_back(mk(1, 5, 3, 0, 0, 22'h000000, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 22'h000000, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 22'h000100, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 1, 22'h000200, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 22'h000200, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 22'h000300, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 22'h000300, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 22'h000400, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 22'h000400, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 22'h000400, 0, 0, 0));
      // Rest dur 2: phase stays 0, sample_valid still pulses, never active.
      vecs.push_back(mk(1, 0, 2, 0, 0, 22'h000000, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 22'h000000, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 22'h000000, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 1, 22'h000000, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 22'h000000, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 22'h000000, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 22'h000000, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 22'h000000, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 22'h000000, 0, 0, 0));
      // Note 7 step 0xFFFFF: accumulate then wrap mod 2^22.
      vecs.push_back(mk(1, 7, 1, 0, 0, 22'h000000, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 22'h000000, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 22'h0FFFFF, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 22'h1FFFFE, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 22'h2FFFFD, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 22'h3FFFFC, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 1, 22'h0FFFFB, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0, 1, 0, 22'h0FFFFB, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 22'h0FFFFB, 0, 0, 0));

      // Reset state
      reset = 1'b1;
      idle_cyc();
      idle_cyc();
      check("rst_addr", 32'(freq_rom_addr), 32'd0);
      check("rst_phase", 32'(phase), 32'd0);
      check("rst_sv", 32'(sample_valid), 32'd0);
      check("rst_done", 32'(done_with_note), 32'd0);
      check("rst_active", 32'(note_active), 32'd0);
      reset = 1'b0;
      idle_cyc();

      foreach (vecs[i]) begin
         cyc(vecs[i].ld, vecs[i].nt, vecs[i].dr, vecs[i].bt, vecs[i].gn);
         check($sformatf("vec%0d_phase", i), 32'(phase), 32'(vecs[i].ph));
         check($sformatf("vec%0d_sv", i), 32'(sample_valid), 32'(vecs[i].sv));
         check($sformatf("vec%0d_done", i), 32'(done_with_note), 32'(vecs[i].dn));
         check($sformatf("vec%0d_active", i), 32'(note_active), 32'(vecs[i].act));
      end
      check("addr_after_vecs", 32'(freq_rom_addr), 32'd7);

      // Pause: note 3 dur 4, one beat, then ten paused beats with requests.
      cyc(1'b1, 6'd3, 6'd4, 1'b0, 1'b0);
      idle_cyc();
      cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b1);
      check("pause_pre_phase", 32'(phase), 32'h10);
      play_enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b1);
         check($sformatf("pause%0d_done", i), 32'(done_with_note), 32'd0);
         check($sformatf("pause%0d_sv", i), 32'(sample_valid), 32'd0);
      end
      check("pause_phase", 32'(phase), 32'h10);
      check("pause_active", 32'(note_active), 32'd1);
      play_enable = 1'b1;
      cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
      check("resume_b1_done", 32'(done_with_note), 32'd0);
      cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
      check("resume_b2_done", 32'(done_with_note), 32'd0);
      cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
      check("resume_b3_done", 32'(done_with_note), 32'd1);
      idle_cyc();
      check("resume_idle_active", 32'(note_active), 32'd0);

      // Duration 0: done two cycles after the load, with no beat.
      cyc(1'b1, 6'd4, 6'd0, 1'b0, 1'b0);
      check("dur0_fetch_done", 32'(done_with_note), 32'd0);
      idle_cyc();
      check("dur0_done", 32'(done_with_note), 32'd1);
      idle_cyc();
      check("dur0_after_done", 32'(done_with_note), 32'd0);
      check("dur0_after_active", 32'(note_active), 32'd0);

      // Retrigger on the final beat: the load wins, phase clears, no done.
      cyc(1'b1, 6'd5, 6'd1, 1'b0, 1'b0);
      idle_cyc();
      cyc(1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
      cyc(1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
      check("retrig_pre_phase", 32'(phase), 32'h200);
      cyc(1'b1, 6'd5, 6'd2, 1'b1, 1'b1);
      check("retrig_done", 32'(done_with_note), 32'd0);
      check("retrig_phase", 32'(phase), 32'd0);
      idle_cyc();
      check("retrig_fetch_done", 32'(done_with_note), 32'd0);
      check("retrig_active", 32'(note_active), 32'd1);
      cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
      check("retrig_b1_done", 32'(done_with_note), 32'd0);
      cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
      check("retrig_b2_done", 32'(done_with_note), 32'd1);

      // Reset mid-note on what would be the final beat.
      cyc(1'b1, 6'd5, 6'd1, 1'b0, 1'b0);
      idle_cyc();
      cyc(1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
      reset = 1'b1;
      cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b1);
      check("midrst_phase", 32'(phase), 32'd0);
      check("midrst_addr", 32'(freq_rom_addr), 32'd0);
      check("midrst_sv", 32'(sample_valid), 32'd0);
      check("midrst_done", 32'(done_with_note), 32'd0);
      check("midrst_active", 32'(note_active), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 6'd0, 6'd0, 1'b1, 1'b1);
         check($sformatf("postrst%0d_done", i), 32'(done_with_note), 32'd0);
         check($sformatf("postrst%0d_sv", i), 32'(sample_valid), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
